// File: rtl/mining_job_scheduler.sv
// -----------------------------------------------------------------------------
// mining_job_scheduler
//
// Purpose:
//   Sequences block-header jobs between a UART receive path, a hashing core
//   and a UART transmit path. A header received while the core is idle is
//   loaded and started at once. A header received while a job is running
//   aborts that job, waits for the core to go quiet and restarts with the new
//   header. Results (found nonce or range exhausted) are presented to the
//   transmitter with a level request that is held until acknowledged.
//   A single pending slot buffers the newest header that could not be
//   loaded immediately.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   hdr_valid/data    one-cycle header pulse from the receive path
//   miner_header      registered header presented to the hashing core
//   miner_start       one-cycle start pulse to the core
//   miner_abort       one-cycle cancel pulse to the core
//   miner_busy        core is hashing (level)
//   miner_found       core found a nonce (pulse), nonce on miner_nonce
//   miner_done        core exhausted its range without a find (pulse)
//   tx_req            level request to the transmitter
//   tx_data/tx_found  result word and its kind, stable while tx_req=1
//   tx_ack            transmitter accepted the result (pulse)
//   state             current FSM encoding, for the display
//   jobs_done         number of acknowledged reports, wraps at 2^16
// -----------------------------------------------------------------------------
module mining_job_scheduler #(
  parameter int HDR_W   = 640,
  parameter int NONCE_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hdr_valid,
  input  logic [HDR_W-1:0]   hdr_data,
  output logic [HDR_W-1:0]   miner_header,
  output logic               miner_start,
  output logic               miner_abort,
  input  logic               miner_busy,
  input  logic               miner_found,
  input  logic               miner_done,
  input  logic [NONCE_W-1:0] miner_nonce,
  output logic               tx_req,
  output logic [NONCE_W-1:0] tx_data,
  output logic               tx_found,
  input  logic               tx_ack,
  output logic [2:0]         state,
  output logic [15:0]        jobs_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_ABORT  = 3'd4
  } state_t;

  state_t               state_q,      state_d;
  logic [HDR_W-1:0]     header_q,     header_d;
  logic [HDR_W-1:0]     pend_hdr_q,   pend_hdr_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [NONCE_W-1:0]   tx_data_q,    tx_data_d;
  logic                 tx_found_q,   tx_found_d;
  logic [15:0]          jobs_q,       jobs_d;
  logic                 start_q,      start_d;
  logic                 abort_q,      abort_d;
  logic                 tx_req_q,     tx_req_d;

  // Set when the incoming header is consumed directly into miner_header,
  // so it must not also land in the pending slot.
  logic                 hdr_taken;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    header_d     = header_q;
    pend_hdr_d   = pend_hdr_q;
    pend_valid_d = pend_valid_q;
    tx_data_d    = tx_data_q;
    tx_found_d   = tx_found_q;
    jobs_d       = jobs_q;
    abort_d      = 1'b0;
    hdr_taken    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdr_valid) begin
          header_d  = hdr_data;
          hdr_taken = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // The start pulse is emitted while in this state; always move on.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A result beats a new header: the header is kept as pending and the
        // finished job is reported instead of being aborted.
        if (miner_found) begin
          tx_data_d  = miner_nonce;
          tx_found_d = 1'b1;
          state_d    = ST_REPORT;
        end else if (miner_done) begin
          tx_data_d  = {NONCE_W{1'b1}};
          tx_found_d = 1'b0;
          state_d    = ST_REPORT;
        end else if (hdr_valid) begin
          abort_d = 1'b1;
          state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        // Wait for the core to stop hashing before handing it the new job.
        if (!miner_busy) begin
          header_d     = pend_hdr_q;
          pend_valid_d = 1'b0;
          state_d      = ST_LOAD;
        end
      end

      ST_REPORT: begin
        if (tx_ack) begin
          jobs_d = jobs_q + 16'd1;
          if (hdr_valid) begin
            // A header arriving with the ack is the newest one; it supersedes
            // anything still pending.
            header_d     = hdr_data;
            hdr_taken    = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_LOAD;
          end else if (pend_valid_q) begin
            header_d     = pend_hdr_q;
            pend_valid_d = 1'b0;
            state_d      = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One-deep pending buffer: the newest header always overwrites.
    if (hdr_valid && !hdr_taken) begin
      pend_hdr_d   = hdr_data;
      pend_valid_d = 1'b1;
    end

    // Pulses and the request level are registered from the next state so
    // they line up with the state they belong to.
    start_d  = (state_d == ST_LOAD);
    tx_req_d = (state_d == ST_REPORT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      header_q     <= '0;
      pend_hdr_q   <= '0;
      pend_valid_q <= 1'b0;
      tx_data_q    <= '0;
      tx_found_q   <= 1'b0;
      jobs_q       <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      tx_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      header_q     <= header_d;
      pend_hdr_q   <= pend_hdr_d;
      pend_valid_q <= pend_valid_d;
      tx_data_q    <= tx_data_d;
      tx_found_q   <= tx_found_d;
      jobs_q       <= jobs_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      tx_req_q     <= tx_req_d;
    end
  end

  assign miner_header = header_q;
  assign miner_start  = start_q;
  assign miner_abort  = abort_q;
  assign tx_req       = tx_req_q;
  assign tx_data      = tx_data_q;
  assign tx_found     = tx_found_q;
  assign state        = state_q;
  assign jobs_done    = jobs_q;

endmodule

// File: tb/tb_mining_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mining_job_scheduler
//
// Stimulus tasks walk the scheduler through jobs, aborts and reports, and for
// every action push the response the scheduler owes (start header and cycle,
// abort cycle, report contents, ack bookkeeping) into queues. A monitor on the
// falling edge pops those queues whenever the DUT shows a start, an abort, a
// rising or falling tx_req, and compares.
// -----------------------------------------------------------------------------
module tb_mining_job_scheduler;

  localparam int HDR_W   = 640;
  localparam int NONCE_W = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               hdr_valid = 1'b0;
  logic [HDR_W-1:0]   hdr_data = '0;
  logic [HDR_W-1:0]   miner_header;
  logic               miner_start;
  logic               miner_abort;
  logic               miner_busy = 1'b0;
  logic               miner_found = 1'b0;
  logic               miner_done = 1'b0;
  logic [NONCE_W-1:0] miner_nonce = '0;
  logic               tx_req;
  logic [NONCE_W-1:0] tx_data;
  logic               tx_found;
  logic               tx_ack = 1'b0;
  logic [2:0]         state;
  logic [15:0]        jobs_done;

  mining_job_scheduler #(.HDR_W(HDR_W), .NONCE_W(NONCE_W)) dut (
    .clock(clock), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data),
    .miner_header(miner_header), .miner_start(miner_start), .miner_abort(miner_abort),
    .miner_busy(miner_busy), .miner_found(miner_found), .miner_done(miner_done),
    .miner_nonce(miner_nonce),
    .tx_req(tx_req), .tx_data(tx_data), .tx_found(tx_found), .tx_ack(tx_ack),
    .state(state), .jobs_done(jobs_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [HDR_W-1:0] hdr; int cyc; } start_exp_t;
  typedef struct { logic found; logic [NONCE_W-1:0] data; int cyc; } rep_exp_t;
  typedef struct { logic [15:0] jobs; logic [2:0] st; int cyc; } ack_exp_t;

  start_exp_t start_q[$];
  int         abort_q[$];
  rep_exp_t   rep_q[$];
  ack_exp_t   ack_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [HDR_W-1:0] act, logic [HDR_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic     prev_req = 1'b0;
  rep_exp_t cur_rep;

  always @(negedge clock) begin : mon
    start_exp_t se;
    ack_exp_t   ae;
    int         ab;
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (miner_start) begin
        chk("start_abort_overlap", miner_abort, 0);
        if (start_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          se = start_q.pop_front();
          chk("start_header", miner_header, se.hdr);
          chk("start_cycle", cyc, se.cyc);
          chk("start_state", state, 1);
        end
      end
      if (miner_abort) begin
        if (abort_q.size() == 0) chk("abort_unexpected", 1, 0);
        else begin
          ab = abort_q.pop_front();
          chk("abort_cycle", cyc, ab);
          chk("abort_state", state, 4);
        end
      end
      if (tx_req && !prev_req) begin
        if (rep_q.size() == 0) chk("report_unexpected", 1, 0);
        else begin
          cur_rep = rep_q.pop_front();
          chk("report_data", tx_data, cur_rep.data);
          chk("report_found", tx_found, cur_rep.found);
          chk("report_cycle", cyc, cur_rep.cyc);
          chk("report_state", state, 3);
        end
      end else if (tx_req) begin
        chk("report_data_hold", tx_data, cur_rep.data);
        chk("report_found_hold", tx_found, cur_rep.found);
      end
      if (!tx_req && prev_req) begin
        if (ack_q.size() == 0) chk("tx_req_drop_unexpected", 1, 0);
        else begin
          ae = ack_q.pop_front();
          chk("jobs_done", jobs_done, ae.jobs);
          chk("after_ack_state", state, ae.st);
          chk("tx_req_fall_cycle", cyc, ae.cyc);
        end
      end
      prev_req = tx_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state and stimulus
  // ---------------------------------------------------------------------------
  logic             m_pend_v = 1'b0;
  logic [HDR_W-1:0] m_pend_h = '0;
  logic [15:0]      m_jobs   = '0;

  function automatic logic [HDR_W-1:0] rand_hdr();
    logic [HDR_W-1:0] h;
    for (int i = 0; i < HDR_W / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    hdr_valid   = 1'b0;
    miner_found = 1'b0;
    miner_done  = 1'b0;
    tx_ack      = 1'b0;
  endtask

  // IDLE -> LOAD
  task automatic t_start(input logic [HDR_W-1:0] h);
    hdr_valid = 1'b1;
    hdr_data  = h;
    start_q.push_back('{h, cyc + 1});
    tick();
  endtask

  // LOAD -> RUN, optionally delivering a header that becomes pending
  task automatic t_load(input bit give, input logic [HDR_W-1:0] h);
    if (give) begin
      hdr_valid = 1'b1; hdr_data = h; m_pend_v = 1'b1; m_pend_h = h;
    end
    tick();
    miner_busy = 1'b1;
  endtask

  // Quiet RUN cycles; a stray tx_ack here must be ignored
  task automatic t_run_idle(input int n);
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) tx_ack = 1'b1;
      tick();
    end
  endtask

  // RUN -> REPORT via found and/or done, optionally with a header alongside
  task automatic t_result(input bit f, input bit d, input logic [NONCE_W-1:0] nonce,
                          input bit give, input logic [HDR_W-1:0] h);
    miner_found = f; miner_done = d; miner_nonce = nonce;
    if (give) begin
      hdr_valid = 1'b1; hdr_data = h; m_pend_v = 1'b1; m_pend_h = h;
    end
    rep_q.push_back('{f, f ? nonce : {NONCE_W{1'b1}}, cyc + 1});
    tick();
    miner_busy = 1'b0;
  endtask

  // REPORT for n cycles (stray found/done ignored), then ack
  task automatic t_report(input int n, output bit to_load);
    repeat (n) begin
      if ($urandom_range(0, 2) == 0) begin
        miner_found = 1'b1; miner_done = $urandom_range(0, 1); miner_nonce = $urandom;
      end
      tick();
    end
    tx_ack = 1'b1;
    m_jobs++;
    to_load = m_pend_v;
    ack_q.push_back('{m_jobs, m_pend_v ? 3'd1 : 3'd0, cyc + 1});
    if (m_pend_v) begin
      start_q.push_back('{m_pend_h, cyc + 1});
      m_pend_v = 1'b0;
    end
    tick();
  endtask

  // RUN -> ABORT -> LOAD: busy held for busy_n ABORT cycles
  task automatic t_abort(input logic [HDR_W-1:0] hb, input int busy_n,
                         input bit extra, input logic [HDR_W-1:0] hx,
                         input bit late, input logic [HDR_W-1:0] hl);
    hdr_valid = 1'b1; hdr_data = hb; m_pend_v = 1'b1; m_pend_h = hb;
    miner_busy = 1'b1;
    abort_q.push_back(cyc + 1);
    tick();
    for (int i = 0; i < busy_n; i++) begin
      if (extra && i == busy_n - 1) begin
        hdr_valid = 1'b1; hdr_data = hx; m_pend_h = hx;
      end
      tick();
    end
    miner_busy = 1'b0;
    start_q.push_back('{m_pend_h, cyc + 1});
    m_pend_v = 1'b0;
    if (late) begin
      hdr_valid = 1'b1; hdr_data = hl; m_pend_v = 1'b1; m_pend_h = hl;
    end
    tick();
  endtask

  task automatic random_session();
    bit to_load;
    int k;
    t_start(rand_hdr());
    to_load = 1'b1;
    while (to_load) begin
      t_load($urandom_range(0, 3) == 0, rand_hdr());
      t_run_idle($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        t_abort(rand_hdr(), $urandom_range(0, 3), $urandom_range(0, 1), rand_hdr(),
                $urandom_range(0, 3) == 0, rand_hdr());
        continue;
      end
      k = $urandom_range(0, 2);
      t_result(k != 1, k != 0, $urandom, $urandom_range(0, 3) == 0, rand_hdr());
      t_report($urandom_range(0, 3), to_load);
    end
    repeat ($urandom_range(1, 3)) begin
      case ($urandom_range(0, 2))
        0: tx_ack = 1'b1;
        1: miner_found = 1'b1;
        default: miner_done = 1'b1;
      endcase
      tick();
    end
  endtask

  initial begin : stim
    logic [HDR_W-1:0] h;
    bit tl;

    // Reset state
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_header", miner_header, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_found", tx_found, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_start", miner_start, 0);
    chk("rst_abort", miner_abort, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_state", state, 0);

    // Basic find: header 0x1234, nonce DEADBEEF
    h = '0; h[31:0] = 32'h0000_1234;
    t_start(h);
    t_load(1'b0, '0);
    t_run_idle(2);
    t_result(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, '0);
    t_report(1, tl);
    chk("first_job_jobs_done", jobs_done, 1);
    chk("first_job_idle", state, 0);

    // Range exhausted
    t_start(rand_hdr());
    t_load(1'b0, '0);
    t_run_idle(1);
    t_result(1'b0, 1'b1, $urandom, 1'b0, '0);
    t_report(2, tl);

    // Abort with busy held 3 cycles, header B
    t_start(rand_hdr());
    t_load(1'b0, '0);
    t_run_idle(1);
    t_abort(rand_hdr(), 3, 1'b0, '0, 1'b0, '0);
    t_load(1'b0, '0);
    t_result(1'b1, 1'b0, $urandom, 1'b0, '0);
    t_report(0, tl);

    // Found together with header C: no abort, C loaded after the ack
    t_start(rand_hdr());
    t_load(1'b0, '0);
    t_result(1'b1, 1'b0, $urandom, 1'b1, rand_hdr());
    t_report(1, tl);
    t_load(1'b0, '0);
    t_result(1'b1, 1'b1, $urandom, 1'b0, '0);
    t_report(0, tl);

    // Randomised sessions
    repeat (40) random_session();

    // Reset in REPORT with a pending header outstanding
    t_start(rand_hdr());
    t_load(1'b1, rand_hdr());
    t_result(1'b1, 1'b0, $urandom, 1'b0, '0);
    tick();
    chk("pre_reset_tx_req", tx_req, 1);
    reset = 1'b1;
    tick();
    chk("reset_report_tx_req", tx_req, 0);
    chk("reset_report_state", state, 0);
    chk("reset_report_jobs", jobs_done, 0);
    chk("reset_report_tx_data", tx_data, 0);
    chk("reset_report_header", miner_header, 0);
    reset = 1'b0;
    m_jobs = '0; m_pend_v = 1'b0;
    tick();
    chk("after_reset_start", miner_start, 0);
    chk("after_reset_abort", miner_abort, 0);
    // Pending was cleared: this job must end in IDLE
    t_start(rand_hdr());
    t_load(1'b0, '0);
    t_result(1'b0, 1'b1, $urandom, 1'b0, '0);
    t_report(0, tl);
    chk("reset_cleared_pending", tl, 0);

    // Counter wrap: back-to-back jobs through the pending slot
    t_start(rand_hdr());
    for (int i = int'(m_jobs); i < 65535; i++) begin
      h = '0; h[31:0] = i; h[HDR_W-1 -: 32] = ~i;
      t_load(1'b1, h);
      t_result(1'b1, 1'b0, i, 1'b0, '0);
      t_report(0, tl);
    end
    chk("jobs_ffff", jobs_done, 16'hFFFF);
    t_load(1'b0, '0);
    t_result(1'b0, 1'b1, '0, 1'b0, '0);
    t_report(0, tl);
    chk("jobs_wrap", jobs_done, 16'h0000);

    repeat (4) tick();
    chk("start_q_drained", start_q.size(), 0);
    chk("abort_q_drained", abort_q.size(), 0);
    chk("rep_q_drained", rep_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mining_job_scheduler.md
MINING_JOB_SCHEDULER -- requirements
Module: mining_job_scheduler

Interface
REQ-001 SHALL have parameter HDR_W, default 640, block-header width in bits.
REQ-002 SHALL have parameter NONCE_W, default 32, nonce width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port hdr_valid, input, 1, one-cycle pulse: new header from the UART receive path.
REQ-006 SHALL have port hdr_data, input, HDR_W, header, sampled only when hdr_valid=1.
REQ-007 SHALL have port miner_header, output, HDR_W, registered header driven to the miner.
REQ-008 SHALL have port miner_start, output, 1, one-cycle pulse to start the miner.
REQ-009 SHALL have port miner_abort, output, 1, one-cycle pulse to cancel the running job.
REQ-010 SHALL have port miner_busy, input, 1, level: the miner is hashing.
REQ-011 SHALL have port miner_found, input, 1, pulse: a satisfactory nonce is present on miner_nonce.
REQ-012 SHALL have port miner_done, input, 1, pulse: nonce range exhausted with no find.
REQ-013 SHALL have port miner_nonce, input, NONCE_W, the winning nonce, valid with miner_found.
REQ-014 SHALL have port tx_req, output, 1, level request to the UART transmitter.
REQ-015 SHALL have port tx_data, output, NONCE_W, result word, stable while tx_req=1.
REQ-016 SHALL have port tx_found, output, 1, 1 = tx_data is a real nonce; 0 = exhausted.
REQ-017 SHALL have port tx_ack, input, 1, pulse: the transmitter accepted tx_data.
REQ-018 SHALL have port state, output, 3, current FSM state encoding, for the display.
REQ-019 SHALL have port jobs_done, output, 16, count of completed reports.

Function
REQ-020 SHALL implement the states IDLE=0, LOAD=1, RUN=2, REPORT=3 and ABORT=4; all other encodings SHALL go to IDLE.
REQ-021 IDLE: on hdr_valid, SHALL latch hdr_data into miner_header and go to LOAD.
REQ-022 LOAD: SHALL assert miner_start for exactly one cycle, then go to RUN (hdr_valid at cycle N in IDLE -> miner_start high at N+1).
REQ-023 RUN on miner_found: SHALL latch miner_nonce into tx_data, set tx_found=1 and go to REPORT; tx_req SHALL be high from the next cycle.
REQ-024 RUN on miner_done: SHALL set tx_data to all-ones and tx_found=0, then go to REPORT.
REQ-025 RUN with found and done in the same cycle: found SHALL win.
REQ-026 RUN on hdr_valid with no found/done: SHALL latch the new header into the pending buffer, pulse miner_abort for one cycle and go to ABORT.
REQ-027 RUN with hdr_valid together with found or done: SHALL store the header as pending and take the found/done path with no abort.
REQ-028 ABORT: SHALL stay until miner_busy=0, then copy pending into miner_header, clear pending and go to LOAD.
REQ-029 REPORT: SHALL hold tx_req=1 with tx_data and tx_found stable until tx_ack; tx_req SHALL fall the cycle after tx_ack.
REQ-030 REPORT on tx_ack: SHALL increment jobs_done by 1 with modulo-2^16 wrap (16'hFFFF -> 0).
REQ-031 REPORT on tx_ack: SHALL go to LOAD (pending moved into miner_header) if pending is valid, else to IDLE.
REQ-032 The pending buffer SHALL be one header deep; a newer hdr_valid SHALL overwrite older pending data.
REQ-033 hdr_valid in LOAD or ABORT SHALL overwrite pending and set it valid; the current load SHALL proceed.
REQ-034 tx_ack outside REPORT, and found/done outside RUN, SHALL be ignored.
REQ-035 miner_start and miner_abort SHALL never be high in the same cycle.

Reset
REQ-036 reset=1 at a rising edge SHALL force IDLE and clear miner_header, tx_data, pending and jobs_done to 0; miner_start, miner_abort, tx_req and tx_found SHALL be 0.
REQ-037 reset SHALL take priority over all other inputs, including mid-RUN and mid-REPORT; no pulse SHALL be emitted in the cycle after reset.

Verification
REQ-038 Bench SHALL cover: hdr_valid with hdr_data[31:0]=32'h0000_1234 -> miner_start at +1, miner_header[31:0]=32'h0000_1234; then miner_found with nonce 32'hDEAD_BEEF -> tx_req=1, tx_data=32'hDEAD_BEEF, tx_found=1; then tx_ack -> IDLE, jobs_done=1.
REQ-039 Bench SHALL cover: miner_done in RUN -> tx_data=32'hFFFF_FFFF, tx_found=0.
REQ-040 Bench SHALL cover: hdr_valid header B in RUN -> one-cycle miner_abort; hold miner_busy=1 for 3 cycles -> miner_start one cycle after busy falls, miner_header=B.
REQ-041 Bench SHALL cover: miner_found and hdr_valid (header C) in the same cycle -> REPORT with no abort; after tx_ack -> LOAD with header C.
REQ-042 Bench SHALL cover: jobs_done preset to 16'hFFFF by 65535 reports, one more report -> 16'h0000.
REQ-043 Bench SHALL cover: reset asserted in REPORT with tx_req=1 -> next cycle tx_req=0, state=0, jobs_done=0.
